// File: rtl/decrypt_arbiter.sv
// decrypt_arbiter: round-robin front end sharing one pipelined decryption core,
// with a flush/flush_done quiesce handshake. Optional counters: DECRYPT_ARB_PERF_EN.
module decrypt_arbiter #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_key,
  input  logic [NREQ*N-1:0] req_e_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      core_key,
  output logic [N-1:0]      core_e_data,
  input  logic [N-1:0]      core_data,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [N-1:0]      rsp_data,
  input  logic              flush,
  output logic              flush_done,
  output logic [1:0]        dbg_state
`ifdef DECRYPT_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0] perf_grants
`endif
);

  // Handshake: a request transfers on a rising edge where req_valid[i] & req_ready[i];
  // req_ready is at most one-hot and only offered in RUN with flush low.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state;
  logic [IW-1:0]            rr_ptr;
  logic [NREQ-1:0]          grant;
  logic [IW-1:0]            grant_id;
  logic                     xfer;
  logic [N-1:0]             sel_key;
  logic [N-1:0]             sel_e_data;
  logic                     issue_v;
  logic [IW-1:0]            issue_id;
  logic [LAT-1:0]           tag_v;
  logic [LAT-1:0][IW-1:0]   tag_id;
  logic                     pipe_busy;

  // Two passes: first from rr_ptr upward, then wrap to the low indices.
  always_comb begin
    grant      = '0;
    grant_id   = '0;
    sel_key    = '0;
    sel_e_data = '0;
    if (!reset && state == RUN && !flush) begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant == '0 && req_valid[i] && IW'(i) >= rr_ptr) begin
          grant[i]   = 1'b1;
          grant_id   = IW'(i);
          sel_key    = req_key[i*N +: N];
          sel_e_data = req_e_data[i*N +: N];
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (grant == '0 && req_valid[i]) begin
          grant[i]   = 1'b1;
          grant_id   = IW'(i);
          sel_key    = req_key[i*N +: N];
          sel_e_data = req_e_data[i*N +: N];
        end
      end
    end
  end

  assign xfer      = |grant;
  assign req_ready = grant;
  assign pipe_busy = issue_v | (|tag_v);
  assign dbg_state = state;

  // issue_* sits alongside the core input register, so the tag reaches the
  // response register together with the matching core_data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      rr_ptr      <= '0;
      core_key    <= '0;
      core_e_data <= '0;
      issue_v     <= 1'b0;
      issue_id    <= '0;
      tag_v       <= '0;
      tag_id      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      flush_done  <= 1'b0;
    end else begin
      if (xfer) begin
        core_key    <= sel_key;
        core_e_data <= sel_e_data;
        rr_ptr      <= (grant_id == IW'(NREQ-1)) ? '0 : grant_id + IW'(1);
      end
      issue_v   <= xfer;
      issue_id  <= grant_id;
      tag_v[0]  <= issue_v;
      tag_id[0] <= issue_id;
      for (int j = 1; j < LAT; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
      rsp_valid <= tag_v[LAT-1];
      if (tag_v[LAT-1]) begin
        rsp_id   <= tag_id[LAT-1];
        rsp_data <= core_data;
      end

      // An empty pipe here means the response register empties on this edge.
      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (!flush) begin
            state <= RUN;
          end else if (!pipe_busy) begin
            state      <= HOLD;
            flush_done <= 1'b1;
          end
        end
        HOLD: begin
          if (!flush) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef DECRYPT_ARB_PERF_EN
  logic [NREQ-1:0][15:0] perf_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_cnt <= '0;
    end else if (flush_done) begin
      perf_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && perf_cnt[i] != 16'hFFFF) perf_cnt[i] <= perf_cnt[i] + 16'd1;
      end
    end
  end

  assign perf_grants = perf_cnt;
`endif

endmodule
